// File: rtl/riscv32ima_pkg.sv
// Shared definitions for the riscv32ima issue path: opcode map, issue FSM
// states and the opcode-class decode helpers used by the issue controller.
package riscv32ima_pkg;

  localparam int RV_OPCODE_WIDTH   = 7;
  localparam int RV_REG_ADDR_WIDTH = 5;

  // Base opcode map (inst[6:0])
  localparam logic [RV_OPCODE_WIDTH-1:0] LOAD      = 7'b0000011;
  localparam logic [RV_OPCODE_WIDTH-1:0] LOAD_FP   = 7'b0000111;
  localparam logic [RV_OPCODE_WIDTH-1:0] CUSTOM_0  = 7'b0001011;
  localparam logic [RV_OPCODE_WIDTH-1:0] MISC_MEM  = 7'b0001111;
  localparam logic [RV_OPCODE_WIDTH-1:0] OP_IMM    = 7'b0010011;
  localparam logic [RV_OPCODE_WIDTH-1:0] AUIPC     = 7'b0010111;
  localparam logic [RV_OPCODE_WIDTH-1:0] OP_IMM_32 = 7'b0011011;
  localparam logic [RV_OPCODE_WIDTH-1:0] STORE     = 7'b0100011;
  localparam logic [RV_OPCODE_WIDTH-1:0] STORE_FP  = 7'b0100111;
  localparam logic [RV_OPCODE_WIDTH-1:0] CUSTOM_1  = 7'b0101011;
  localparam logic [RV_OPCODE_WIDTH-1:0] AMO       = 7'b0101111;
  localparam logic [RV_OPCODE_WIDTH-1:0] OP        = 7'b0110011;
  localparam logic [RV_OPCODE_WIDTH-1:0] LUI       = 7'b0110111;
  localparam logic [RV_OPCODE_WIDTH-1:0] OP_32     = 7'b0111011;
  localparam logic [RV_OPCODE_WIDTH-1:0] MADD      = 7'b1000011;
  localparam logic [RV_OPCODE_WIDTH-1:0] MSUB      = 7'b1000111;
  localparam logic [RV_OPCODE_WIDTH-1:0] NMSUB     = 7'b1001011;
  localparam logic [RV_OPCODE_WIDTH-1:0] NMADD     = 7'b1001111;
  localparam logic [RV_OPCODE_WIDTH-1:0] OP_FP     = 7'b1010011;
  localparam logic [RV_OPCODE_WIDTH-1:0] CUSTOM_2  = 7'b1011011;
  localparam logic [RV_OPCODE_WIDTH-1:0] BRANCH    = 7'b1100011;
  localparam logic [RV_OPCODE_WIDTH-1:0] JALR      = 7'b1100111;
  localparam logic [RV_OPCODE_WIDTH-1:0] JAL       = 7'b1101111;
  localparam logic [RV_OPCODE_WIDTH-1:0] SYSTEM    = 7'b1110011;
  localparam logic [RV_OPCODE_WIDTH-1:0] CUSTOM_3  = 7'b1111011;

  // Issue FSM: normal issue, drain for serializing ops, wait for control transfer
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    BR_WAIT = 2'd2
  } issue_state_e;

  function automatic logic uses_rs1(input logic [RV_OPCODE_WIDTH-1:0] opc);
    case (opc)
      LOAD, OP_IMM, STORE, AMO, OP, BRANCH, JALR, SYSTEM: uses_rs1 = 1'b1;
      default:                                             uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [RV_OPCODE_WIDTH-1:0] opc);
    case (opc)
      STORE, AMO, OP, BRANCH: uses_rs2 = 1'b1;
      default:                uses_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [RV_OPCODE_WIDTH-1:0] opc);
    case (opc)
      LOAD, OP_IMM, AUIPC, AMO, OP, LUI, JALR, JAL, SYSTEM: writes_rd = 1'b1;
      default:                                              writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic is_serial(input logic [RV_OPCODE_WIDTH-1:0] opc);
    case (opc)
      SYSTEM, MISC_MEM: is_serial = 1'b1;
      default:          is_serial = 1'b0;
    endcase
  endfunction

  function automatic logic is_ctrl(input logic [RV_OPCODE_WIDTH-1:0] opc);
    case (opc)
      BRANCH, JAL, JALR: is_ctrl = 1'b1;
      default:           is_ctrl = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv32ima_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register. A set (issue)
// wins over a same-cycle clear (write-back) of the same register; x0 is never
// marked. eff is the pending set with the current write-back already removed,
// so a same-cycle write-back bypasses hazards.
module riscv32ima_scoreboard
  import riscv32ima_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             set_en,
  input  logic [REG_ADDR_WIDTH-1:0]        set_addr,
  input  logic                             clr_en,
  input  logic [REG_ADDR_WIDTH-1:0]        clr_addr,
  output logic [(2**REG_ADDR_WIDTH)-1:0]   pending,
  output logic [(2**REG_ADDR_WIDTH)-1:0]   eff,
  output logic                             empty,
  output logic                             eff_empty
);

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;

  // Decode set/clear requests into one-hot masks; x0 is never marked pending
  always_comb begin
    set_mask_s = {NUM_REGS{1'b0}};
    clr_mask_s = {NUM_REGS{1'b0}};
    if (set_en && (set_addr != {REG_ADDR_WIDTH{1'b0}})) begin
      set_mask_s[set_addr] = 1'b1;
    end else begin
      set_mask_s = {NUM_REGS{1'b0}};
    end
    if (clr_en) begin
      clr_mask_s[clr_addr] = 1'b1;
    end else begin
      clr_mask_s = {NUM_REGS{1'b0}};
    end
  end

  // Pending vector update: clear first, then set, so issue wins over write-back
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pending_r <= {NUM_REGS{1'b0}};
    end else begin
      pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
    end
  end

  assign pending   = pending_r;
  assign eff       = pending_r & ~clr_mask_s;
  assign empty     = (pending_r == {NUM_REGS{1'b0}});
  assign eff_empty = (eff == {NUM_REGS{1'b0}});

endmodule

// File: rtl/riscv32ima_issue_ctrl.sv
// In-order issue controller between the decoder and the ALU. Holds a single
// registered issue slot, stalls on RAW/WAW hazards against pending writes,
// serializes SYSTEM/MISC_MEM and blocks after any control transfer until
// write-back resolves it (no speculation).
module riscv32ima_issue_ctrl
  import riscv32ima_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int OPCODE_WIDTH   = 7,
  parameter int FUNC3_WIDTH    = 3,
  parameter int FUNC7_WIDTH    = 7
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic [OPCODE_WIDTH-1:0]   dec_opcode,
  input  logic [FUNC3_WIDTH-1:0]    dec_func3_opcode,
  input  logic [FUNC7_WIDTH-1:0]    dec_func7_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] dec_src0_addr,
  input  logic [REG_ADDR_WIDTH-1:0] dec_src1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] dec_dst_addr,
  input  logic [ADDR_WIDTH-1:0]     dec_mem_addr,
  input  logic [DATA_WIDTH-1:0]     dec_src0_data,
  input  logic [DATA_WIDTH-1:0]     dec_src1_data,
  input  logic [DATA_WIDTH-1:0]     dec_imm_data,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [OPCODE_WIDTH-1:0]   iss_opcode,
  output logic [FUNC3_WIDTH-1:0]    iss_func3_opcode,
  output logic [FUNC7_WIDTH-1:0]    iss_func7_opcode,
  output logic [REG_ADDR_WIDTH-1:0] iss_src0_addr,
  output logic [REG_ADDR_WIDTH-1:0] iss_src1_addr,
  output logic [REG_ADDR_WIDTH-1:0] iss_dst_addr,
  output logic [ADDR_WIDTH-1:0]     iss_mem_addr,
  output logic [DATA_WIDTH-1:0]     iss_src0_data,
  output logic [DATA_WIDTH-1:0]     iss_src1_data,
  output logic [DATA_WIDTH-1:0]     iss_imm_data,
  input  logic                      wback_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wback_reg_addr,
  input  logic                      wback_pc_wen,
  input  logic                      wback_br_done,
  output logic                      busy
);

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

  issue_state_e        state_r;
  issue_state_e        state_nxt_s;

  logic                uses_rs1_s;
  logic                uses_rs2_s;
  logic                writes_rd_s;
  logic                serial_s;
  logic                ctrl_s;

  logic [NUM_REGS-1:0] sb_pending_s;
  logic [NUM_REGS-1:0] eff_s;
  logic                sb_empty_s;
  logic                eff_empty_s;

  logic                hazard_s;
  logic                serial_block_s;
  logic                slot_free_s;
  logic                accept_s;

  // Classify the instruction currently offered by the decoder
  always_comb begin
    uses_rs1_s  = uses_rs1(dec_opcode);
    uses_rs2_s  = uses_rs2(dec_opcode);
    writes_rd_s = writes_rd(dec_opcode);
    serial_s    = is_serial(dec_opcode);
    ctrl_s      = is_ctrl(dec_opcode);
  end

  // Hazard terms against the effective pending set (same-cycle write-back bypassed)
  always_comb begin
    hazard_s       = (uses_rs1_s  && eff_s[dec_src0_addr]) ||
                     (uses_rs2_s  && eff_s[dec_src1_addr]) ||
                     (writes_rd_s && eff_s[dec_dst_addr]);
    serial_block_s = serial_s && (!eff_empty_s || iss_valid);
    slot_free_s    = !iss_valid || iss_ready;
  end

  assign accept_s = dec_valid && dec_ready;

  riscv32ima_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_scoreboard (
    .clk       (clk),
    .nrst      (nrst),
    .set_en    (accept_s && writes_rd_s),
    .set_addr  (dec_dst_addr),
    .clr_en    (wback_reg_wen),
    .clr_addr  (wback_reg_addr),
    .pending   (sb_pending_s),
    .eff       (eff_s),
    .empty     (sb_empty_s),
    .eff_empty (eff_empty_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: enter DRAIN/BR_WAIT on accept, leave on drain or resolution
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (accept_s && serial_s) begin
          state_nxt_s = DRAIN;
        end else if (accept_s && ctrl_s) begin
          state_nxt_s = BR_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (!iss_valid && eff_empty_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      BR_WAIT: begin
        if (wback_pc_wen || wback_br_done) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = BR_WAIT;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // FSM output: decoder handshake only while running with a free, hazard-free slot
  always_comb begin
    dec_ready = 1'b0;
    case (state_r)
      RUN: begin
        if (slot_free_s && !hazard_s && !serial_block_s) begin
          dec_ready = 1'b1;
        end else begin
          dec_ready = 1'b0;
        end
      end
      DRAIN:   dec_ready = 1'b0;
      BR_WAIT: dec_ready = 1'b0;
      default: dec_ready = 1'b0;
    endcase
  end

  // Issue slot: load on accept, empty when the ALU takes it, hold while stalled
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      iss_valid        <= 1'b0;
      iss_opcode       <= {OPCODE_WIDTH{1'b0}};
      iss_func3_opcode <= {FUNC3_WIDTH{1'b0}};
      iss_func7_opcode <= {FUNC7_WIDTH{1'b0}};
      iss_src0_addr    <= {REG_ADDR_WIDTH{1'b0}};
      iss_src1_addr    <= {REG_ADDR_WIDTH{1'b0}};
      iss_dst_addr     <= {REG_ADDR_WIDTH{1'b0}};
      iss_mem_addr     <= {ADDR_WIDTH{1'b0}};
      iss_src0_data    <= {DATA_WIDTH{1'b0}};
      iss_src1_data    <= {DATA_WIDTH{1'b0}};
      iss_imm_data     <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      iss_valid        <= 1'b1;
      iss_opcode       <= dec_opcode;
      iss_func3_opcode <= dec_func3_opcode;
      iss_func7_opcode <= dec_func7_opcode;
      iss_src0_addr    <= dec_src0_addr;
      iss_src1_addr    <= dec_src1_addr;
      iss_dst_addr     <= dec_dst_addr;
      iss_mem_addr     <= dec_mem_addr;
      iss_src0_data    <= dec_src0_data;
      iss_src1_data    <= dec_src1_data;
      iss_imm_data     <= dec_imm_data;
    end else if (iss_valid && iss_ready) begin
      iss_valid        <= 1'b0;
    end
  end

  assign busy = (state_r != RUN) || !sb_empty_s || iss_valid;

endmodule

// File: tb/tb_riscv32ima_issue_ctrl.sv
// Directed bench for riscv32ima_issue_ctrl: accepted instructions are queued
// as expected issues and compared field-by-field when the ALU side takes them.
module tb_riscv32ima_issue_ctrl;
  import riscv32ima_pkg::*;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [63:0] imm;
  } ins_t;

  logic        clk;
  logic        nrst;
  logic        dec_valid;
  logic        dec_ready;
  logic [6:0]  dec_opcode;
  logic [2:0]  dec_func3_opcode;
  logic [6:0]  dec_func7_opcode;
  logic [4:0]  dec_src0_addr;
  logic [4:0]  dec_src1_addr;
  logic [4:0]  dec_dst_addr;
  logic [31:0] dec_mem_addr;
  logic [63:0] dec_src0_data;
  logic [63:0] dec_src1_data;
  logic [63:0] dec_imm_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [6:0]  iss_opcode;
  logic [2:0]  iss_func3_opcode;
  logic [6:0]  iss_func7_opcode;
  logic [4:0]  iss_src0_addr;
  logic [4:0]  iss_src1_addr;
  logic [4:0]  iss_dst_addr;
  logic [31:0] iss_mem_addr;
  logic [63:0] iss_src0_data;
  logic [63:0] iss_src1_data;
  logic [63:0] iss_imm_data;
  logic        wback_reg_wen;
  logic [4:0]  wback_reg_addr;
  logic        wback_pc_wen;
  logic        wback_br_done;
  logic        busy;

  int   vec_cnt    = 0;
  int   miscmp_cnt = 0;
  int   pc_seq     = 0;
  ins_t exp_q[$];

  riscv32ima_issue_ctrl dut (
    .clk              (clk),
    .nrst             (nrst),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .dec_opcode       (dec_opcode),
    .dec_func3_opcode (dec_func3_opcode),
    .dec_func7_opcode (dec_func7_opcode),
    .dec_src0_addr    (dec_src0_addr),
    .dec_src1_addr    (dec_src1_addr),
    .dec_dst_addr     (dec_dst_addr),
    .dec_mem_addr     (dec_mem_addr),
    .dec_src0_data    (dec_src0_data),
    .dec_src1_data    (dec_src1_data),
    .dec_imm_data     (dec_imm_data),
    .iss_valid        (iss_valid),
    .iss_ready        (iss_ready),
    .iss_opcode       (iss_opcode),
    .iss_func3_opcode (iss_func3_opcode),
    .iss_func7_opcode (iss_func7_opcode),
    .iss_src0_addr    (iss_src0_addr),
    .iss_src1_addr    (iss_src1_addr),
    .iss_dst_addr     (iss_dst_addr),
    .iss_mem_addr     (iss_mem_addr),
    .iss_src0_data    (iss_src0_data),
    .iss_src1_data    (iss_src1_data),
    .iss_imm_data     (iss_imm_data),
    .wback_reg_wen    (wback_reg_wen),
    .wback_reg_addr   (wback_reg_addr),
    .wback_pc_wen     (wback_pc_wen),
    .wback_br_done    (wback_br_done),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscmp_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t t;
    t.opcode = op;
    t.f3     = 3'($urandom_range(7, 0));
    t.f7     = 7'($urandom_range(127, 0));
    t.rs1    = rs1;
    t.rs2    = rs2;
    t.rd     = rd;
    pc_seq   = pc_seq + 1;
    t.pc     = 32'h0000_1000 + 32'(pc_seq * 4);
    t.d0     = {$urandom(), $urandom()};
    t.d1     = {$urandom(), $urandom()};
    t.imm    = {$urandom(), $urandom()};
    return t;
  endfunction

  function automatic ins_t obs_fields();
    return {iss_opcode, iss_func3_opcode, iss_func7_opcode, iss_src0_addr,
            iss_src1_addr, iss_dst_addr, iss_mem_addr, iss_src0_data,
            iss_src1_data, iss_imm_data};
  endfunction

  task automatic drive(input ins_t t);
    dec_valid        = 1'b1;
    dec_opcode       = t.opcode;
    dec_func3_opcode = t.f3;
    dec_func7_opcode = t.f7;
    dec_src0_addr    = t.rs1;
    dec_src1_addr    = t.rs2;
    dec_dst_addr     = t.rd;
    dec_mem_addr     = t.pc;
    dec_src0_data    = t.d0;
    dec_src1_data    = t.d1;
    dec_imm_data     = t.imm;
  endtask

  // Present t for one cycle, check the handshake, queue it if it should be taken
  task automatic step_send(input ins_t t, input logic exp_rdy, input string tag);
    drive(t);
    @(negedge clk);
    chk(tag, 256'(dec_ready), 256'(exp_rdy));
    if (exp_rdy) exp_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic step_idle();
    dec_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Issue-side scoreboard: each ALU handshake must match the oldest accepted instruction
  always @(negedge clk) begin
    if (nrst && iss_valid && iss_ready) begin
      chk("issue_expected", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) begin
        chk("issue_fields", obs_fields(), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d", vec_cnt);
    $fatal(1);
  end

  initial begin
    ins_t a, b, c, d;
    nrst             = 1'b0;
    dec_valid        = 1'b0;
    dec_opcode       = 7'd0;
    dec_func3_opcode = 3'd0;
    dec_func7_opcode = 7'd0;
    dec_src0_addr    = 5'd0;
    dec_src1_addr    = 5'd0;
    dec_dst_addr     = 5'd0;
    dec_mem_addr     = 32'd0;
    dec_src0_data    = 64'd0;
    dec_src1_data    = 64'd0;
    dec_imm_data     = 64'd0;
    iss_ready        = 1'b1;
    wback_reg_wen    = 1'b0;
    wback_reg_addr   = 5'd0;
    wback_pc_wen     = 1'b0;
    wback_br_done    = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_iss_valid", 256'(iss_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_iss_fields", obs_fields(), 256'(0));
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // RAW stall on x3, released by same-cycle write-back bypass
    step_send(mk(OP, 5'd3, 5'd1, 5'd2), 1'b1, "op_x3");
    a = mk(OP, 5'd4, 5'd3, 5'd1);
    step_send(a, 1'b0, "raw_stall0");
    step_send(a, 1'b0, "raw_stall1");
    wback_reg_wen  = 1'b1;
    wback_reg_addr = 5'd3;
    step_send(a, 1'b1, "raw_bypass");
    wback_reg_wen  = 1'b0;
    dec_valid      = 1'b0;
    @(negedge clk);
    chk("raw_iss_valid", 256'(iss_valid), 256'(1));
    chk("raw_iss_rd", 256'(iss_dst_addr), 256'(4));
    @(posedge clk);
    #1;

    // WAW stall on x4; same-cycle clear and set of x4 keeps it pending
    b = mk(OP_IMM, 5'd4, 5'd0, 5'd0);
    step_send(b, 1'b0, "waw_stall");
    wback_reg_wen  = 1'b1;
    wback_reg_addr = 5'd4;
    step_send(b, 1'b1, "waw_bypass");
    wback_reg_wen  = 1'b0;
    c = mk(OP, 5'd13, 5'd4, 5'd0);
    step_send(c, 1'b0, "set_wins");
    wback_reg_wen  = 1'b1;
    wback_reg_addr = 5'd4;
    step_send(c, 1'b1, "x4_released");
    wback_reg_addr = 5'd13;
    step_idle();
    wback_reg_wen  = 1'b0;

    // x0 is never pending
    step_send(mk(LUI, 5'd0, 5'd0, 5'd0), 1'b1, "lui_x0");
    step_idle();
    @(negedge clk);
    chk("x0_not_pending", 256'(busy), 256'(0));
    @(posedge clk);
    #1;
    step_send(mk(OP, 5'd5, 5'd0, 5'd0), 1'b1, "op_x0_src");
    wback_reg_wen  = 1'b1;
    wback_reg_addr = 5'd5;
    step_idle();
    wback_reg_wen  = 1'b0;

    // ALU back-pressure holds the slot, then 1/cycle throughput
    iss_ready = 1'b0;
    a = mk(OP_32, 5'd1, 5'd2, 5'd3);
    step_send(a, 1'b1, "hold_first");
    b = mk(OP_32, 5'd2, 5'd3, 5'd4);
    for (int i = 0; i < 3; i++) begin
      drive(b);
      @(negedge clk);
      chk("hold_ready", 256'(dec_ready), 256'(0));
      chk("hold_valid", 256'(iss_valid), 256'(1));
      chk("hold_fields", obs_fields(), a);
      @(posedge clk);
      #1;
    end
    iss_ready = 1'b1;
    step_send(b, 1'b1, "resume_b");
    c = mk(OP_32, 5'd3, 5'd4, 5'd5);
    d = mk(OP_32, 5'd6, 5'd7, 5'd8);
    step_send(c, 1'b1, "b2b_c");
    step_send(d, 1'b1, "b2b_d");
    step_idle();

    // BRANCH waits for wback_br_done
    step_send(mk(BRANCH, 5'd0, 5'd0, 5'd0), 1'b1, "branch");
    a = mk(OP_32, 5'd9, 5'd9, 5'd9);
    for (int i = 0; i < 5; i++) step_send(a, 1'b0, "br_wait");
    wback_br_done = 1'b1;
    step_send(a, 1'b0, "br_done_cycle");
    wback_br_done = 1'b0;
    step_send(a, 1'b1, "br_resume");

    // JAL waits for wback_pc_wen
    step_send(mk(JAL, 5'd0, 5'd0, 5'd0), 1'b1, "jal");
    b = mk(OP_32, 5'd10, 5'd10, 5'd10);
    for (int i = 0; i < 5; i++) step_send(b, 1'b0, "jal_wait");
    wback_pc_wen = 1'b1;
    step_send(b, 1'b0, "pc_wen_cycle");
    wback_pc_wen = 1'b0;
    step_send(b, 1'b1, "jal_resume");

    // SYSTEM waits for pending x6/x7, then drains until its own write-back
    step_send(mk(OP_IMM, 5'd6, 5'd0, 5'd0), 1'b1, "x6");
    step_send(mk(OP_IMM, 5'd7, 5'd0, 5'd0), 1'b1, "x7");
    c = mk(SYSTEM, 5'd10, 5'd0, 5'd0);
    step_send(c, 1'b0, "sys_wait0");
    wback_reg_wen  = 1'b1;
    wback_reg_addr = 5'd6;
    step_send(c, 1'b0, "sys_wait_x6");
    wback_reg_addr = 5'd7;
    step_send(c, 1'b1, "sys_accept");
    wback_reg_wen  = 1'b0;
    d = mk(OP_32, 5'd11, 5'd11, 5'd11);
    step_send(d, 1'b0, "drain0");
    step_send(d, 1'b0, "drain1");
    chk("drain_busy", 256'(busy), 256'(1));
    wback_reg_wen  = 1'b1;
    wback_reg_addr = 5'd10;
    step_send(d, 1'b0, "drain_wb");
    wback_reg_wen  = 1'b0;
    step_send(d, 1'b1, "drain_resume");
    step_idle();
    step_idle();
    @(negedge clk);
    chk("drain_idle_busy", 256'(busy), 256'(0));
    @(posedge clk);
    #1;

    // Asynchronous reset in BR_WAIT with x11 pending
    step_send(mk(OP_IMM, 5'd11, 5'd0, 5'd0), 1'b1, "x11");
    step_send(mk(BRANCH, 5'd0, 5'd0, 5'd0), 1'b1, "br2");
    dec_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", 256'(busy), 256'(1));
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_valid", 256'(iss_valid), 256'(0));
    chk("async_rst_busy", 256'(busy), 256'(0));
    chk("async_rst_fields", obs_fields(), 256'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 256'(busy), 256'(0));
    @(posedge clk);
    #1;
    step_send(mk(OP, 5'd12, 5'd11, 5'd0), 1'b1, "x11_forgotten");
    wback_reg_wen  = 1'b1;
    wback_reg_addr = 5'd12;
    step_idle();
    wback_reg_wen  = 1'b0;
    step_idle();
    step_idle();
    @(negedge clk);
    chk("queue_drained", 256'(exp_q.size()), 256'(0));
    chk("final_busy", 256'(busy), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
